// File: rtl/majority_serial_ctrl_if.sv
// Handshake bundle for the serial majority engine: word in on in_*, vote result out on out_*.
// The engine takes the slave side; the producer/consumer (or bench) takes the master side.
interface majority_serial_ctrl_if #(
  parameter int SIZE  = 9,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [SIZE-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_y;
  logic [CNT_W-1:0] out_count;
  logic             busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_y, out_count, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_y, out_count, busy
  );
endinterface

// File: rtl/majority_serial_ctrl.sv
// Serial majority voter: counts the ones of one accepted word a bit per cycle through a
// single adder, then holds ones count and majority flag on a valid/ready result port.
module majority_serial_ctrl #(
  parameter int          SIZE     = 9,
  parameter int unsigned MAJORITY = 5,
  parameter int          CNT_W    = 4
) (
  input logic                  clk,
  input logic                  rst,
  majority_serial_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [SIZE-1:0]  sh;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_nxt;
  logic [CNT_W-1:0] res_count;
  logic             res_y;
  logic             last;

  // acc_nxt already includes the bit being consumed, so on the last bit it is the final count
  assign acc_nxt = acc + CNT_W'(sh[0]);
  assign last    = (idx == CNT_W'(SIZE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sh        <= '0;
      idx       <= '0;
      acc       <= '0;
      res_count <= '0;
      res_y     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            sh    <= bus.in_data;
            acc   <= '0;
            idx   <= '0;
            state <= S_COUNT;
          end
        end
        S_COUNT: begin
          acc <= acc_nxt;
          sh  <= sh >> 1;
          idx <= idx + CNT_W'(1);
          if (last) begin
            state     <= S_DONE;
            res_count <= acc_nxt;
            res_y     <= (32'(acc_nxt) >= MAJORITY);
          end
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // in_ready only in IDLE: a result consume and a new accept never share a cycle
  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.out_count = res_count;
  assign bus.out_y     = res_y;
endmodule
